player_health_ctrl: RTL
=======================

// Module: player_health_ctrl
// PURPOSE
//  Parametrised lives/damage controller for the player ship, the next generation of the fixed
//  4-life logic. Merges N masked collision sources, runs an ALIVE/INVULN/DEAD state machine with a
//  frame-counted invulnerability blink, and awards bonus lives. Also draws the lives HUD row and
//  feeds the chosen icon's offsets to livesBitMap. Sits in player between collision bus and bitmaps.
// PARAMETERS
//  LIVES_MAX      4    saturation ceiling for remaining_lives (1..2**LIVES_WIDTH-1)
//  LIVES_INIT     4    lives loaded at reset (1..LIVES_MAX)
//  LIVES_WIDTH    3    width of remaining_lives
//  N_SRC          4    number of damage collision inputs
//  INVULN_FRAMES  60   frames of invulnerability after a non-fatal hit (>=1)
//  BLINK_FRAMES   8    frames per half-period of player_faded toggling (>=1)
//  HUD_X0, HUD_Y0 32, 467  top-left of HUD icon 0
//  HUD_PITCH      16   X distance between consecutive icons; ICON_SIZE 8: square icon edge
//  REGEN_FRAMES   600  only used with PLAYER_HEALTH_REGEN_EN
// PORTS
//  clk              in   1            system clock
//  resetN           in   1            synchronous, active-low reset
//  enable           in   1            game running; gates frame ticks and hit latching
//  startOfFrame     in   1            one-cycle pulse per frame
//  collision        in   N_SRC        per-source damage collision, level during pixel scan
//  src_mask         in   N_SRC        1 = source may damage the player
//  bonus_life       in   1            one-cycle pulse, award one life
//  pixelX, pixelY   in   11 (coordinate)  current scan pixel
//  remaining_lives  out  LIVES_WIDTH  current lives
//  player_damaged   out  1            high in INVULN
//  player_faded     out  1            blink phase (1 = ship hidden)
//  player_dead      out  1            high in DEAD
//  hud_inside       out  1            pixel inside a live HUD icon (to livesBitMap InsideRectangle)
//  hud_offsetX/Y    out  11           pixel offset inside that icon
// BEHAVIOUR
//  Reset (resetN=0 at clk edge): state ALIVE, remaining_lives=LIVES_INIT, all 1-bit outputs 0,
//   hud_offsetX/Y=0, hit_pending=0, bonus_pending=0, counters 0.
//  tick = startOfFrame & enable. hit_pending sets on any cycle with enable & |(collision & src_mask);
//   bonus_pending sets on bonus_life (any enable state). Both cleared on each tick after evaluation.
//  ALIVE on tick: hit only -> lives-1; if result 0 -> DEAD, else INVULN, cnt=INVULN_FRAMES.
//   bonus only -> lives+1 saturating at LIVES_MAX. hit+bonus same frame -> lives unchanged,
//   enter INVULN. Neither -> stay.
//  INVULN on tick: hits discarded; bonus applied (saturating); cnt-1; every BLINK_FRAMES ticks
//   player_faded toggles (first toggle on first tick after entry, faded=1). cnt reaches 0 ->
//   ALIVE, player_faded=0 in the same cycle.
//  DEAD: sticky until reset; hits and bonuses ignored; remaining_lives=0, player_faded=0.
//  Outputs change the cycle after the tick edge (1-cycle latency). enable=0 freezes state/counters.
//  HUD: icon i (0..LIVES_MAX-1) covers X in [HUD_X0+i*HUD_PITCH, +ICON_SIZE), Y in
//   [HUD_Y0, +ICON_SIZE), drawn only if i < remaining_lives. hud_inside/offsets registered, 1-cycle
//   latency from pixelX/Y; overlapping icons -> lowest index wins; outside -> offsets 0.
// CONFIGURATION
//  PLAYER_HEALTH_REGEN_EN defined: in ALIVE, a frame counter counts ticks without hit; at
//   REGEN_FRAMES it adds one life if lives < LIVES_INIT and restarts; any hit or leaving ALIVE
//   clears it. Undefined: no regen counter, lives rise only via bonus_life.
// TESTING
//  Reset, LIVES_INIT=4 -> remaining_lives=4, dead/damaged/faded=0, hud_inside 0 off-row.
//  collision[1]=1 one cycle, mask=4'hF, tick -> lives=3, damaged=1 for exactly 60 ticks, faded
//   toggles every 8 ticks, back to ALIVE with faded=0.
//  mask=4'b1101, collision[1] only -> no damage; hits during INVULN -> lives unchanged.
//  4 hits spaced >60 frames -> lives 0, player_dead=1; later bonus_life -> still 0/dead.
//  lives=4 + bonus -> stays 4; lives=1 with hit+bonus same frame -> lives=1, INVULN, not dead.
//  lives=2: pixel (48..55,467..474) -> hud_inside=1, offsetX=pixelX-48; pixel x=64 -> 0 (icon 2 off).

Source files
------------

// File: rtl/player_health_ctrl.sv
// Player lives/damage controller: masked collision merge, ALIVE/INVULN/DEAD FSM with blink, bonus lives, HUD row.
// Optional frame-counted life regeneration is enabled by defining PLAYER_HEALTH_REGEN_EN.
module player_health_ctrl #(
    parameter int unsigned LIVES_MAX     = 4,
    parameter int unsigned LIVES_INIT    = 4,
    parameter int unsigned LIVES_WIDTH   = 3,
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES  = 8,
    parameter int unsigned HUD_X0        = 32,
    parameter int unsigned HUD_Y0        = 467,
    parameter int unsigned HUD_PITCH     = 16,
    parameter int unsigned ICON_SIZE     = 8,
    parameter int unsigned REGEN_FRAMES  = 600
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   enable,
    input  logic                   startOfFrame,
    input  logic [N_SRC-1:0]       collision,
    input  logic [N_SRC-1:0]       src_mask,
    input  logic                   bonus_life,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    output logic [LIVES_WIDTH-1:0] remaining_lives,
    output logic                   player_damaged,
    output logic                   player_faded,
    output logic                   player_dead,
    output logic                   hud_inside,
    output logic [10:0]            hud_offsetX,
    output logic [10:0]            hud_offsetY
);

    localparam int unsigned CNT_W   = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
`ifdef PLAYER_HEALTH_REGEN_EN
    localparam int unsigned REGEN_W = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
`endif

    // Elaboration-time guard on the configuration space.
    if ((LIVES_INIT < 1) || (LIVES_INIT > LIVES_MAX) || (LIVES_MAX > ((1 << LIVES_WIDTH) - 1)) ||
        (N_SRC < 1) || (INVULN_FRAMES < 1) || (BLINK_FRAMES < 1) || (ICON_SIZE < 1) ||
        (REGEN_FRAMES < 1)) begin : g_bad_params
        $error("player_health_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

    state_e                 state_q;
    logic [LIVES_WIDTH-1:0] lives_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BLK_W-1:0]       blink_q;
    logic                   hit_pending_q;
    logic                   bonus_pending_q;
    logic                   damaged_q;
    logic                   faded_q;
    logic                   dead_q;
`ifdef PLAYER_HEALTH_REGEN_EN
    logic [REGEN_W-1:0]     regen_q;
`endif

    logic                   tick;
    logic                   hit_now;
    logic                   hit_evt;
    logic                   bonus_evt;
    logic [LIVES_WIDTH-1:0] lives_inc;
    logic [LIVES_WIDTH-1:0] lives_dec;

    assign tick      = startOfFrame & enable;
    assign hit_now   = enable & (|(collision & src_mask));
    assign hit_evt   = hit_pending_q | hit_now;
    assign bonus_evt = bonus_pending_q | bonus_life;
    assign lives_inc = (lives_q < LIVES_WIDTH'(LIVES_MAX)) ? (lives_q + LIVES_WIDTH'(1)) : lives_q;
    assign lives_dec = lives_q - LIVES_WIDTH'(1);

    // Per-frame event latches; consumed and cleared on every tick.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hit_pending_q   <= 1'b0;
            bonus_pending_q <= 1'b0;
        end else if (tick) begin
            hit_pending_q   <= 1'b0;
            bonus_pending_q <= 1'b0;
        end else begin
            if (hit_now) begin
                hit_pending_q <= 1'b1;
            end
            if (bonus_life) begin
                bonus_pending_q <= 1'b1;
            end
        end
    end

    // Health state machine; everything advances only on frame ticks.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= ST_ALIVE;
            lives_q   <= LIVES_WIDTH'(LIVES_INIT);
            cnt_q     <= '0;
            blink_q   <= '0;
            damaged_q <= 1'b0;
            faded_q   <= 1'b0;
            dead_q    <= 1'b0;
`ifdef PLAYER_HEALTH_REGEN_EN
            regen_q   <= '0;
`endif
        end else if (tick) begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit_evt && !bonus_evt && (lives_q == LIVES_WIDTH'(1))) begin
                        state_q <= ST_DEAD;
                        lives_q <= '0;
                        dead_q  <= 1'b1;
                    end else if (hit_evt) begin
                        // A bonus in the same frame cancels the life loss but not the hit.
                        if (!bonus_evt) begin
                            lives_q <= lives_dec;
                        end
                        state_q   <= ST_INVULN;
                        cnt_q     <= CNT_W'(INVULN_FRAMES);
                        blink_q   <= '0;
                        damaged_q <= 1'b1;
                        faded_q   <= 1'b0;
                    end else if (bonus_evt) begin
                        lives_q <= lives_inc;
                    end
`ifdef PLAYER_HEALTH_REGEN_EN
                    if (hit_evt) begin
                        regen_q <= '0;
                    end else if (regen_q == REGEN_W'(REGEN_FRAMES - 1)) begin
                        regen_q <= '0;
                        if (!bonus_evt && (lives_q < LIVES_WIDTH'(LIVES_INIT))) begin
                            lives_q <= lives_q + LIVES_WIDTH'(1);
                        end
                    end else begin
                        regen_q <= regen_q + REGEN_W'(1);
                    end
`endif
                end
                ST_INVULN: begin
                    if (bonus_evt) begin
                        lives_q <= lives_inc;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= ST_ALIVE;
                        damaged_q <= 1'b0;
                        faded_q   <= 1'b0;
                        blink_q   <= '0;
                    end else if (blink_q == '0) begin
                        faded_q <= ~faded_q;
                        blink_q <= BLK_W'(BLINK_FRAMES - 1);
                    end else begin
                        blink_q <= blink_q - BLK_W'(1);
                    end
`ifdef PLAYER_HEALTH_REGEN_EN
                    regen_q <= '0;
`endif
                end
                ST_DEAD: begin
                    lives_q   <= '0;
                    damaged_q <= 1'b0;
                    faded_q   <= 1'b0;
                    dead_q    <= 1'b1;
`ifdef PLAYER_HEALTH_REGEN_EN
                    regen_q   <= '0;
`endif
                end
                default: begin
                    state_q   <= ST_DEAD;
                    lives_q   <= '0;
                    damaged_q <= 1'b0;
                    faded_q   <= 1'b0;
                    dead_q    <= 1'b1;
                end
            endcase
        end
    end

    // HUD icon hit test; lowest visible icon index wins on overlap.
    logic [31:0] px;
    logic [31:0] py;
    logic        hud_in_d;
    logic [10:0] hud_ox_d;
    logic [10:0] hud_oy_d;

    assign px = 32'(pixelX);
    assign py = 32'(pixelY);

    always_comb begin
        hud_in_d = 1'b0;
        hud_ox_d = '0;
        hud_oy_d = '0;
        for (int unsigned i = 0; i < LIVES_MAX; i++) begin
            if (!hud_in_d && (i < 32'(lives_q)) &&
                (py >= HUD_Y0) && (py < (HUD_Y0 + ICON_SIZE)) &&
                (px >= (HUD_X0 + i * HUD_PITCH)) &&
                (px < (HUD_X0 + i * HUD_PITCH + ICON_SIZE))) begin
                hud_in_d = 1'b1;
                hud_ox_d = 11'(px - (HUD_X0 + i * HUD_PITCH));
                hud_oy_d = 11'(py - HUD_Y0);
            end
        end
    end

    logic        hud_in_q;
    logic [10:0] hud_ox_q;
    logic [10:0] hud_oy_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            hud_in_q <= 1'b0;
            hud_ox_q <= '0;
            hud_oy_q <= '0;
        end else begin
            hud_in_q <= hud_in_d;
            hud_ox_q <= hud_ox_d;
            hud_oy_q <= hud_oy_d;
        end
    end

    assign remaining_lives = lives_q;
    assign player_damaged  = damaged_q;
    assign player_faded    = faded_q;
    assign player_dead     = dead_q;
    assign hud_inside      = hud_in_q;
    assign hud_offsetX     = hud_ox_q;
    assign hud_offsetY     = hud_oy_q;

endmodule
